rv32i_mc_ctrl: RTL and testbench

Parametrised multi-cycle RV32I control unit with bus handshakes, the next generation of the two-state Fetch/Execute controller.
- Adds memory wait states with a ready handshake, a dedicated load/store phase and bus timeouts.
- Adds illegal-instruction and ECALL/EBREAK trapping with acknowledge, and a retired-instruction counter.
- Sits between the unified memory port, the instruction register, the PC register and the datapath control fields.

---
 rtl/rv32i_ctrl_pkg.sv | 87 ++++++++
 rtl/rv32i_mc_ctrl_if.sv | 32 +++
 rtl/rv32i_decode.sv | 95 +++++++++
 rtl/rv32i_mc_ctrl.sv | 126 ++++++++++++
 tb/tb_rv32i_mc_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, ALU
// mode codes, FSM state encoding, trap causes, ctrl_bus field offsets and
// the select codes carried inside ctrl_bus.
package rv32i_ctrl_pkg;

  localparam int CTRL_W = 20;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0]  F7_BASE     = 7'b0000000;
  localparam logic [6:0]  F7_ALT      = 7'b0100000;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_MEM     = 2'd2,
    ST_TRAP    = 2'd3
  } state_t;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd1;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd2;
  localparam logic [2:0] CAUSE_ECALL   = 3'd3;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd4;

  // ctrl_bus field LSB positions
  localparam int B_REG_WE  = 19;
  localparam int B_PC_SEL  = 13;
  localparam int B_MEM_WE  = 3;

  localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
  localparam logic [1:0] PCSEL_ALU    = 2'b01;
  localparam logic [1:0] PCSEL_TARGET = 2'b10;
  localparam logic [1:0] PCSEL_TRAP   = 2'b11;

  localparam logic [1:0] RSEL_MEM = 2'b00;
  localparam logic [1:0] RSEL_ALU = 2'b01;
  localparam logic [1:0] RSEL_PC4 = 2'b10;
  localparam logic [1:0] RSEL_IMM = 2'b11;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_I    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_J    = 3'b101;

  // Fetch drives only the memory-data input enable (bit 4).
  localparam logic [CTRL_W-1:0] CTRL_FETCH = 20'h00010;

  function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_mc_ctrl_if.sv
// Control-unit bus bundle.
//   master: the control unit (drives ctrl_bus, selects, enables, trap status, instret)
//   slave : memory/datapath/trap-handler side (drives inst, jump, mem_ready, trap_ack)
interface rv32i_mc_ctrl_if #(
  parameter int INSTRET_W = 32
);
  logic [31:0]          inst;
  logic                 jump;
  logic                 mem_ready;
  logic                 trap_ack;
  logic [19:0]          ctrl_bus;
  logic                 addrs_SEL;
  logic                 pc_EN;
  logic                 instr_EN;
  logic                 mem_req;
  logic                 retire;
  logic                 trap_valid;
  logic [2:0]           trap_cause;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  inst, jump, mem_ready, trap_ack,
    output ctrl_bus, addrs_SEL, pc_EN, instr_EN, mem_req, retire,
           trap_valid, trap_cause, instret
  );

  modport slave (
    output inst, jump, mem_ready, trap_ack,
    input  ctrl_bus, addrs_SEL, pc_EN, instr_EN, mem_req, retire,
           trap_valid, trap_cause, instret
  );
endinterface

// File: rtl/rv32i_decode.sv
// Combinational RV32I decoder.
//   inst, jump -> ctrl (20-bit datapath control word), is_load, is_store,
//   illegal, ecall, ebreak. ctrl is all-zero for anything that traps.
module rv32i_decode
  import rv32i_ctrl_pkg::*;
#(
  parameter bit FENCE_AS_NOP = 1'b1
) (
  input  logic [31:0]       inst,
  input  logic              jump,
  output logic [CTRL_W-1:0] ctrl,
  output logic              is_load,
  output logic              is_store,
  output logic              illegal,
  output logic              ecall,
  output logic              ebreak
);
  logic [6:0] opcode, funct7;
  logic [2:0] funct3, imm_sel, mem_mode;
  logic [1:0] reg_sel, pc_sel;
  logic [3:0] alu_mode;
  logic       reg_we, rs1_sel, rs2_sel, alu_mem_en, mem_in_en, mem_we;
  logic       load_c, store_c, bad;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    reg_we = 1'b0; rs1_sel = 1'b0; rs2_sel = 1'b0; alu_mem_en = 1'b0;
    mem_in_en = 1'b0; mem_we = 1'b0; reg_sel = RSEL_MEM; pc_sel = PCSEL_PLUS4;
    imm_sel = IMM_NONE; alu_mode = ALU_ADD; mem_mode = 3'b000;
    load_c = 1'b0; store_c = 1'b0; bad = 1'b0; ecall = 1'b0; ebreak = 1'b0;
    case (opcode)
      OPC_LUI: begin
        reg_we = 1'b1; reg_sel = RSEL_IMM; imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        reg_we = 1'b1; rs1_sel = 1'b1; rs2_sel = 1'b1; reg_sel = RSEL_ALU; imm_sel = IMM_U;
      end
      OPC_JAL: begin
        reg_we = 1'b1; reg_sel = RSEL_PC4; pc_sel = PCSEL_TARGET; imm_sel = IMM_J;
      end
      OPC_JALR: begin
        reg_we = 1'b1; rs2_sel = 1'b1; reg_sel = RSEL_PC4; pc_sel = PCSEL_ALU; imm_sel = IMM_I;
        bad = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm_sel  = IMM_B;
        alu_mode = (funct3[2:1] == 2'b00) ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
        // jump is the raw comparator result; BNE branches on its inverse.
        pc_sel   = (jump ^ (funct3 == 3'b001)) ? PCSEL_TARGET : PCSEL_PLUS4;
        bad      = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        reg_we = 1'b1; rs2_sel = 1'b1; reg_sel = RSEL_MEM; imm_sel = IMM_I;
        alu_mem_en = 1'b1; mem_in_en = 1'b1; mem_mode = funct3; load_c = 1'b1;
        bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        rs2_sel = 1'b1; imm_sel = IMM_S; alu_mem_en = 1'b1; mem_we = 1'b1;
        mem_mode = funct3; store_c = 1'b1;
        bad = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        reg_we = 1'b1; rs2_sel = 1'b1; reg_sel = RSEL_ALU; imm_sel = IMM_I;
        // funct7 only qualifies the shifts; for the rest those bits are immediate.
        alu_mode = alu_op(funct3, funct7[5] && (funct3 == 3'b101));
        bad = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
              ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
      end
      OPC_OP: begin
        reg_we = 1'b1; reg_sel = RSEL_ALU; alu_mode = alu_op(funct3, funct7[5]);
        bad = !((funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_MISC_MEM: bad = !FENCE_AS_NOP;
      OPC_SYSTEM: begin
        ecall  = (inst == INST_ECALL);
        ebreak = (inst == INST_EBREAK);
        bad    = !(ecall || ebreak);
      end
      default: bad = 1'b1;
    endcase

    illegal  = bad;
    is_load  = load_c && !bad;
    is_store = store_c && !bad;
    if (bad || ecall || ebreak)
      ctrl = '0;
    else
      ctrl = {reg_we, rs1_sel, rs2_sel, reg_sel, pc_sel, imm_sel, alu_mode,
              alu_mem_en, mem_in_en, mem_we, mem_mode};
  end
endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control unit: FETCH -> EXECUTE -> (MEM) -> FETCH, with
// memory wait states, bus timeout, illegal/ECALL/EBREAK trapping and a
// retired-instruction counter.
//   clk, reset : clock, synchronous active-high reset (forces all outputs to 0)
//   bus        : master side of rv32i_mc_ctrl_if (inst/jump/mem_ready/trap_ack in;
//                ctrl_bus, selects, enables, retire, trap status, instret out)
module rv32i_mc_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 16,
  parameter int TIMER_W      = 5,
  parameter int INSTRET_W    = 32,
  parameter bit FENCE_AS_NOP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  rv32i_mc_ctrl_if.master  bus
);
  logic [CTRL_W-1:0]    dec_ctrl, ctrl_c;
  logic                 is_load, is_store, illegal, ecall, ebreak, timeout;
  logic                 addrs_sel_c, pc_en_c, instr_en_c, mem_req_c, retire_c;
  state_t               state;
  logic [TIMER_W-1:0]   wait_cnt;
  logic [2:0]           cause_q;
  logic [INSTRET_W-1:0] instret_q;

  rv32i_decode #(.FENCE_AS_NOP(FENCE_AS_NOP)) u_decode (
    .inst(bus.inst), .jump(bus.jump), .ctrl(dec_ctrl), .is_load(is_load),
    .is_store(is_store), .illegal(illegal), .ecall(ecall), .ebreak(ebreak)
  );

  // Fires in the cycle whose missing mem_ready would complete MEM_TIMEOUT
  // waited cycles; a mem_ready in that same cycle still completes normally.
  assign timeout = (MEM_TIMEOUT != 0) && !bus.mem_ready &&
                   ((wait_cnt + 1'b1) == TIMER_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      wait_cnt  <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      if (retire_c) instret_q <= instret_q + 1'b1;
      // The counter is held at 0 outside FETCH/MEM and cleared on every exit,
      // so each FETCH/MEM visit starts counting from 0.
      wait_cnt <= '0;
      case (state)
        ST_FETCH, ST_MEM: begin
          if (bus.mem_ready) begin
            state <= (state == ST_FETCH) ? ST_EXECUTE : ST_FETCH;
          end else if (timeout) begin
            state   <= ST_TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_EXECUTE: begin
          if (illegal) begin
            state <= ST_TRAP; cause_q <= CAUSE_ILLEGAL;
          end else if (ecall) begin
            state <= ST_TRAP; cause_q <= CAUSE_ECALL;
          end else if (ebreak) begin
            state <= ST_TRAP; cause_q <= CAUSE_EBREAK;
          end else if (is_load || is_store) begin
            state <= ST_MEM;
          end else begin
            state <= ST_FETCH;
          end
        end
        default: begin
          if (bus.trap_ack) begin
            state   <= ST_FETCH;
            cause_q <= CAUSE_NONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    ctrl_c = '0; addrs_sel_c = 1'b0; pc_en_c = 1'b0;
    instr_en_c = 1'b0; mem_req_c = 1'b0; retire_c = 1'b0;
    case (state)
      ST_FETCH: begin
        ctrl_c = CTRL_FETCH; addrs_sel_c = 1'b1; mem_req_c = 1'b1;
        instr_en_c = bus.mem_ready;
      end
      ST_EXECUTE: begin
        ctrl_c = dec_ctrl;
        // Traps and memory ops commit nothing here; memory ops commit in MEM.
        if (illegal || ecall || ebreak || is_load || is_store) begin
          ctrl_c[B_REG_WE] = 1'b0;
          ctrl_c[B_MEM_WE] = 1'b0;
        end else begin
          pc_en_c  = 1'b1;
          retire_c = 1'b1;
        end
      end
      ST_MEM: begin
        ctrl_c = dec_ctrl;
        mem_req_c = 1'b1;
        ctrl_c[B_REG_WE] = dec_ctrl[B_REG_WE] && bus.mem_ready;
        pc_en_c  = bus.mem_ready;
        retire_c = bus.mem_ready;
      end
      default: begin
        if (bus.trap_ack) begin
          pc_en_c = 1'b1;
          ctrl_c[B_PC_SEL +: 2] = PCSEL_TRAP;
        end
      end
    endcase
  end

  assign bus.ctrl_bus   = reset ? '0 : ctrl_c;
  assign bus.addrs_SEL  = !reset && addrs_sel_c;
  assign bus.pc_EN      = !reset && pc_en_c;
  assign bus.instr_EN   = !reset && instr_en_c;
  assign bus.mem_req    = !reset && mem_req_c;
  assign bus.retire     = !reset && retire_c;
  assign bus.trap_valid = !reset && (state == ST_TRAP);
  assign bus.trap_cause = reset ? CAUSE_NONE : cause_q;
  assign bus.instret    = reset ? '0 : instret_q;
endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
module tb_rv32i_mc_ctrl;
  typedef struct packed {
    logic [31:0] inst;
    logic        jump;
    logic [19:0] ctrl;   // expected ctrl_bus in EXECUTE
    logic [2:0]  cause;  // 0 = retires, else expected trap cause
  } vec_t;

  localparam int NV = 23;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_instret = 32'd0;
  vec_t        vecs [NV];
  vec_t        sb [$];

  always #5 clk = ~clk;

  rv32i_mc_ctrl_if #(.INSTRET_W(32)) bus ();

  rv32i_mc_ctrl #(
    .MEM_TIMEOUT(4), .TIMER_W(3), .INSTRET_W(32), .FENCE_AS_NOP(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {bus.ctrl_bus, bus.addrs_SEL, bus.pc_EN, bus.instr_EN, bus.mem_req,
               bus.retire, bus.trap_valid, bus.trap_cause, bus.instret}, 64'd0);
  endtask

  // Acknowledge a pending trap and confirm the return to FETCH.
  task automatic ack_trap(input string name, input logic [2:0] cause);
    chk({name, "_valid"}, {bus.trap_valid, bus.trap_cause, bus.mem_req}, {1'b1, cause, 1'b0});
    chk({name, "_ctrl"}, bus.ctrl_bus, 20'h00000);
    bus.trap_ack = 1'b1; #1;
    chk({name, "_ack"}, {bus.pc_EN, bus.retire, bus.ctrl_bus}, {2'b10, 20'h06000});
    cyc();
    bus.trap_ack = 1'b0; #1;
    chk({name, "_cleared"}, {bus.trap_valid, bus.trap_cause, bus.addrs_SEL}, {1'b0, 3'd0, 1'b1});
    chk({name, "_instret"}, bus.instret, exp_instret);
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    bus.inst = v.inst; bus.jump = v.jump; bus.mem_ready = 1'b1; bus.trap_ack = 1'b0;
    sb.push_back(v);
    #1;
    chk("fetch_sel", {bus.addrs_SEL, bus.mem_req, bus.instr_EN, bus.pc_EN, bus.retire}, 5'b11100);
    chk("fetch_ctrl", bus.ctrl_bus, 20'h00010);
    cyc();
    #1;
    e = sb.pop_front();
    chk("exec_ctrl", bus.ctrl_bus, e.ctrl);
    if (e.cause == 3'd0) begin
      chk("exec_retire", {bus.pc_EN, bus.retire}, 2'b11);
      exp_instret++;
      cyc();
      chk("instret", bus.instret, exp_instret);
    end else begin
      chk("exec_hold", {bus.pc_EN, bus.retire}, 2'b00);
      cyc();
      ack_trap("trap", e.cause);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h00500093, 1'b0, 20'hA8C00, 3'd0}; // ADDI
    vecs[1]  = '{32'h002081B3, 1'b0, 20'h88000, 3'd0}; // ADD
    vecs[2]  = '{32'h402081B3, 1'b0, 20'h88040, 3'd0}; // SUB
    vecs[3]  = '{32'h4020D1B3, 1'b0, 20'h881C0, 3'd0}; // SRA
    vecs[4]  = '{32'h4020C1B3, 1'b0, 20'h00000, 3'd2}; // XOR with funct7 0100000
    vecs[5]  = '{32'h4030D093, 1'b0, 20'hA8DC0, 3'd0}; // SRAI
    vecs[6]  = '{32'h40309093, 1'b0, 20'h00000, 3'd2}; // SLLI with funct7 0100000
    vecs[7]  = '{32'h123452B7, 1'b0, 20'h99000, 3'd0}; // LUI
    vecs[8]  = '{32'h000000EF, 1'b0, 20'h95400, 3'd0}; // JAL
    vecs[9]  = '{32'h000100E7, 1'b0, 20'hB2C00, 3'd0}; // JALR
    vecs[10] = '{32'h000110E7, 1'b0, 20'h00000, 3'd2}; // JALR funct3 001
    vecs[11] = '{32'h00208463, 1'b1, 20'h04840, 3'd0}; // BEQ taken
    vecs[12] = '{32'h00209463, 1'b1, 20'h00840, 3'd0}; // BNE, jump=1 -> not taken
    vecs[13] = '{32'h00209463, 1'b0, 20'h04840, 3'd0}; // BNE, jump=0 -> taken
    vecs[14] = '{32'h0020A463, 1'b1, 20'h00000, 3'd2}; // branch funct3 010
    vecs[15] = '{32'hFFFFFFFF, 1'b0, 20'h00000, 3'd2}; // unknown opcode
    vecs[16] = '{32'h00000073, 1'b0, 20'h00000, 3'd3}; // ECALL
    vecs[17] = '{32'h00100073, 1'b0, 20'h00000, 3'd4}; // EBREAK
    vecs[18] = '{32'h0000000F, 1'b0, 20'h00000, 3'd0}; // FENCE as NOP
    vecs[19] = '{32'h0010B093, 1'b0, 20'hA8E40, 3'd0}; // SLTIU
    vecs[20] = '{32'h00001097, 1'b0, 20'hE9000, 3'd0}; // AUIPC
    vecs[21] = '{32'h0000B103, 1'b0, 20'h00000, 3'd2}; // load funct3 011
    vecs[22] = '{32'h0020B023, 1'b0, 20'h00000, 3'd2}; // store funct3 011

    // Reset with busy inputs: every output must read 0.
    reset = 1'b1; bus.inst = 32'h00500093; bus.jump = 1'b1;
    bus.mem_ready = 1'b1; bus.trap_ack = 1'b1;
    cyc(); cyc();
    chk_all_zero("reset_outs");
    reset = 1'b0; bus.trap_ack = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // LW: three wait cycles, ready on the fourth (also the timeout cycle).
    bus.inst = 32'h0000A103; bus.mem_ready = 1'b1; #1;
    cyc();
    bus.mem_ready = 1'b0; #1;
    chk("lw_exec_ctrl", bus.ctrl_bus, 20'h20C32);
    chk("lw_exec_hold", {bus.pc_EN, bus.retire}, 2'b00);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait", {bus.addrs_SEL, bus.mem_req, bus.pc_EN, bus.retire, bus.trap_valid}, 5'b01000);
      chk("lw_wait_ctrl", bus.ctrl_bus, 20'h20C32);
      cyc();
    end
    bus.mem_ready = 1'b1; #1;
    chk("lw_done", {bus.pc_EN, bus.retire, bus.ctrl_bus}, {2'b11, 20'hA0C32});
    exp_instret++;
    cyc();
    chk("lw_instret", {bus.addrs_SEL, bus.instret}, {1'b1, exp_instret});

    // SW with no mem_ready: four store cycles, then bus-timeout trap.
    bus.inst = 32'h0020A023; #1;
    cyc();
    bus.mem_ready = 1'b0; #1;
    chk("sw_exec_ctrl", bus.ctrl_bus, 20'h20422);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("sw_wait_ctrl", bus.ctrl_bus, 20'h2042A);
      chk("sw_wait", {bus.addrs_SEL, bus.mem_req, bus.pc_EN, bus.trap_valid}, 4'b0100);
      cyc();
    end
    ack_trap("sw_timeout", 3'd1);

    // Fetch timeout: memory never answers the instruction fetch.
    bus.mem_ready = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("fetch_wait", {bus.addrs_SEL, bus.mem_req, bus.instr_EN, bus.trap_valid}, 4'b1100);
      cyc();
    end
    ack_trap("fetch_timeout", 3'd1);

    // Reset in the middle of a MEM wait abandons the load.
    bus.inst = 32'h0000A103; bus.mem_ready = 1'b1; #1;
    cyc();
    bus.mem_ready = 1'b0;
    cyc(); cyc();
    chk("mid_mem", {bus.addrs_SEL, bus.mem_req}, 2'b01);
    reset = 1'b1; bus.mem_ready = 1'b1; bus.trap_ack = 1'b1; #1;
    chk_all_zero("reset_mem_outs");
    cyc();
    chk_all_zero("reset_mem_outs2");
    reset = 1'b0; bus.inst = 32'h00500093; exp_instret = 32'd0; #1;
    chk("post_reset_fetch", {bus.addrs_SEL, bus.mem_req, bus.instr_EN, bus.instret}, {3'b111, 32'd0});
    cyc();
    // trap_ack is still high here and must have no effect.
    chk("post_reset_exec", {bus.ctrl_bus, bus.pc_EN, bus.retire}, {20'hA8C00, 2'b11});
    exp_instret++;
    cyc();
    chk("post_reset_instret", bus.instret, exp_instret);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
